pixel_fetch_sequencer: RTL and testbench
========================================

# pixel_fetch_sequencer

Controller that sequences per-pixel, per-layer framebuffer reads for the GPU engine. It walks x/y over the frame and, at each pixel, walks the active layers. It issues one RAM read request per layer and emits single-cycle next_layer / next_pixel pulses. It sits between the frame-start logic, the layer RAM read port and the compositor input stage.

## Interface
Parameters:
- H_RES, 1920, pixels per line; x range 0..H_RES-1
- V_RES, 1080, lines per frame; y range 0..V_RES-1
- MAX_LAYERS, 32, upper bound on layers per pixel

Ports:
- clk  in  1  master clock; single clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- num_layers  in  6  active layers per pixel; sampled on accepted start
- layer_en  in  32  per-layer enable mask; present only with SBX_LAYER_SKIP_EN
- rd_req  out  1  read request valid for (layer, x, y)
- rd_ack  in  1  RAM accepts request; transfer = rd_req & rd_ack
- pix_ready  in  1  compositor ready to take the completed pixel
- layer  out  5  current layer index
- x  out  11  current column
- y  out  11  current line
- next_layer  out  1  one-cycle pulse, layer advanced
- next_pixel  out  1  one-cycle pulse, pixel advanced
- frame_done  out  1  one-cycle pulse after last pixel of frame
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, REQ, PIX, DONE.
- IDLE: busy=0, rd_req=0. start=1 latches the layer limit L, zeroes layer/x/y, and moves to REQ.
- L is num_layers clamped: 0 becomes 1; values above MAX_LAYERS become MAX_LAYERS.
- REQ: rd_req=1.
  - Transfer with layer < L-1: layer increments and next_layer pulses; state stays REQ.
  - Transfer with layer = L-1: go to PIX.
  - No transfer: hold state.
- PIX: rd_req=0. When pix_ready=1:
  - next_pixel pulses and layer clears to 0.
  - x increments; at x=H_RES-1, x wraps to 0 and y increments.
  - If x=H_RES-1 and y=V_RES-1, go to DONE. Otherwise go to REQ.
- DONE: frame_done pulses for one cycle, x/y/layer return to 0, state goes to IDLE.
- start while busy is ignored. rd_ack while rd_req=0 is ignored. pix_ready outside PIX is ignored.
- num_layers changes mid-frame have no effect until the next accepted start.
- Reset in any state, including mid-transfer:
  - Next cycle: IDLE, and all outputs 0 (rd_req, layer, x, y, next_layer, next_pixel, frame_done, busy).
  - Any pending request is abandoned; the RAM side must tolerate the dropped request.

## Timing
- All outputs are registered; all inputs are sampled on rising clk.
- start at edge N: busy=1 and rd_req=1 from cycle N+1, with layer=0, x=0, y=0.
- Transfer at edge N: layer, next_layer, or state change is visible in cycle N+1.
- Peak throughput: one layer per cycle with rd_ack held high.
- Per pixel with rd_ack and pix_ready held high: L cycles in REQ plus 1 in PIX = L+1 cycles.
- next_layer and next_pixel are never high for more than one consecutive cycle, and never high in the same cycle.
- Layer L-1 transfer does not pulse next_layer; the pixel's layer advance is the next_pixel pulse.
- frame_done is high in the cycle after the last next_pixel. busy falls in the cycle after frame_done.
- Full frame with L=1 and no stalls: 2·H_RES·V_RES + 1 cycles from first rd_req to frame_done.

## Configuration
- SBX_LAYER_SKIP_EN defined:
  - layer_en port exists.
  - In REQ, if layer_en[layer]=0, rd_req stays 0 and the layer is treated as transferred that cycle (advance or go to PIX, same rules). Each skipped layer costs one cycle.
  - Bits at and above L are ignored.
  - A pixel with all layers disabled still passes through PIX and pulses next_pixel.
- SBX_LAYER_SKIP_EN undefined: layer_en port is absent and every layer below L is requested.

## Test plan
- Use H_RES=4, V_RES=2 and tie pix_ready=1 unless stated.
- Reset and idle: assert reset for 2 cycles, then release.
  - Required: all outputs 0.
  - start=0 for 10 cycles: rd_req never asserts.
- Basic frame: num_layers=3, start pulse, rd_ack=1.
  - Required: 8 pixels × (2 next_layer + 1 next_pixel).
  - Layer sequence per pixel: 0,1,2.
  - x/y order: (0,0)..(3,0),(0,1)..(3,1).
  - frame_done exactly once, 33 cycles after first rd_req.
- Backpressure: num_layers=2.
  - Hold rd_ack=0 for 5 cycles on layer 1: rd_req and layer=1 must stay stable.
  - Hold pix_ready=0 for 4 cycles in PIX: no next_pixel, x unchanged.
- Clamping: num_layers=0 gives 1 layer per pixel. num_layers=40 gives layers 0..31, then next_pixel.
- Reset mid-frame: assert reset while in REQ with x=2, y=1, layer=1.
  - Required: next cycle IDLE, all outputs 0.
  - A new start restarts at (0,0,0).
- Skip (SBX_LAYER_SKIP_EN): num_layers=4, layer_en=0b1010.
  - Required: rd_req only for layers 1 and 3.
  - Layer sequence 0,1,2,3 with one cycle per skipped layer.
  - layer_en=0 gives next_pixel every 5 cycles with no rd_req.

Source files
------------

// File: rtl/pixel_fetch_sequencer.sv
// pixel_fetch_sequencer
// Walks x/y across the frame and, at each pixel, walks the active layers,
// issuing one layer RAM read per enabled layer and pulsing next_layer /
// next_pixel / frame_done for the compositor.
//
// Optional feature: define SBX_LAYER_SKIP_EN to add the layer_en port.
// Layers whose enable bit is low are passed over in one cycle without a read.
// Without the macro every layer below the latched limit is requested.

module pixel_fetch_sequencer #(
    parameter int H_RES      = 1920,
    parameter int V_RES      = 1080,
    parameter int MAX_LAYERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  num_layers,
`ifdef SBX_LAYER_SKIP_EN
    input  logic [31:0] layer_en,
`endif
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic        pix_ready,
    output logic [4:0]  layer,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        next_layer,
    output logic        next_pixel,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        PIX,
        DONE
    } stateT;

    localparam logic [10:0] X_LAST   = 11'(H_RES - 1);
    localparam logic [10:0] Y_LAST   = 11'(V_RES - 1);
    localparam logic [5:0]  LAYER_CAP = 6'(MAX_LAYERS);

    stateT       state;
    logic [4:0]  lastLayer;
    logic [5:0]  clampedLayers;
    logic [4:0]  startLastLayer;
    logic [4:0]  layerPlusOne;
    logic        firstLayerEnabled;
    logic        nextLayerEnabled;
    logic        advance;

    // Clamp the requested layer count into 1..MAX_LAYERS and derive the index
    // of the last layer so the walk can compare against it directly.
    always_comb begin
        clampedLayers = num_layers;
        if (num_layers == 6'd0) begin
            clampedLayers = 6'd1;
        end else if (num_layers > LAYER_CAP) begin
            clampedLayers = LAYER_CAP;
        end
        startLastLayer = 5'(clampedLayers - 6'd1);
    end

    // Decide whether the layer about to be presented needs a read, and whether
    // the current layer is finished (either its read was accepted, or it was
    // skipped and rd_req was never raised for it).
    always_comb begin
        layerPlusOne = layer + 5'd1;
`ifdef SBX_LAYER_SKIP_EN
        firstLayerEnabled = layer_en[0];
        nextLayerEnabled  = layer_en[layerPlusOne];
`else
        firstLayerEnabled = 1'b1;
        nextLayerEnabled  = 1'b1;
`endif
        advance = (rd_req & rd_ack) | ~rd_req;
    end

    // Sequencer: every output is a register updated alongside the state, so
    // pulses appear in the cycle after the event that caused them. DONE lasts
    // two cycles so that busy stays high through the frame_done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lastLayer  <= 5'd0;
            rd_req     <= 1'b0;
            layer      <= 5'd0;
            x          <= 11'd0;
            y          <= 11'd0;
            next_layer <= 1'b0;
            next_pixel <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            next_layer <= 1'b0;
            next_pixel <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    rd_req <= 1'b0;
                    busy   <= 1'b0;
                    if (start) begin
                        lastLayer <= startLastLayer;
                        layer     <= 5'd0;
                        x         <= 11'd0;
                        y         <= 11'd0;
                        busy      <= 1'b1;
                        rd_req    <= firstLayerEnabled;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    if (advance) begin
                        if (layer != lastLayer) begin
                            layer      <= layerPlusOne;
                            next_layer <= 1'b1;
                            rd_req     <= nextLayerEnabled;
                        end else begin
                            rd_req <= 1'b0;
                            state  <= PIX;
                        end
                    end
                end

                PIX: begin
                    if (pix_ready) begin
                        next_pixel <= 1'b1;
                        layer      <= 5'd0;
                        if (x == X_LAST) begin
                            x <= 11'd0;
                            if (y == Y_LAST) begin
                                y      <= 11'd0;
                                rd_req <= 1'b0;
                                state  <= DONE;
                            end else begin
                                y      <= y + 11'd1;
                                rd_req <= firstLayerEnabled;
                                state  <= REQ;
                            end
                        end else begin
                            x      <= x + 11'd1;
                            rd_req <= firstLayerEnabled;
                            state  <= REQ;
                        end
                    end
                end

                DONE: begin
                    rd_req <= 1'b0;
                    layer  <= 5'd0;
                    x      <= 11'd0;
                    y      <= 11'd0;
                    if (!frame_done) begin
                        frame_done <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    rd_req <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_fetch_sequencer.sv
// Testbench for pixel_fetch_sequencer on a 4x2 frame.
// Define SBX_LAYER_SKIP_EN to also exercise the per-layer skip feature.

module tb_pixel_fetch_sequencer;

    localparam int H = 4;
    localparam int V = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  num_layers = 6'd0;
    logic        rd_ack = 1'b0;
    logic        pix_ready = 1'b1;
`ifdef SBX_LAYER_SKIP_EN
    logic [31:0] layer_en = 32'hFFFF_FFFF;
`endif
    logic        rd_req;
    logic [4:0]  layer;
    logic [10:0] x;
    logic [10:0] y;
    logic        next_layer;
    logic        next_pixel;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int failures = 0;

    pixel_fetch_sequencer #(
        .H_RES(H),
        .V_RES(V),
        .MAX_LAYERS(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_layers(num_layers),
`ifdef SBX_LAYER_SKIP_EN
        .layer_en(layer_en),
`endif
        .rd_req(rd_req),
        .rd_ack(rd_ack),
        .pix_ready(pix_ready),
        .layer(layer),
        .x(x),
        .y(y),
        .next_layer(next_layer),
        .next_pixel(next_pixel),
        .frame_done(frame_done),
        .busy(busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        rd_ack = 1'b0;
        pix_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        int reqSeen;
        apply_reset();
        obs = {rd_req, next_layer, next_pixel, frame_done, busy, layer, x, y};
        checks++;
        if (obs !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %08h expected %08h", obs, 32'h0);
        end
        rd_ack = 1'b1;
        reqSeen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd_req !== 1'b0 || busy !== 1'b0) reqSeen++;
        end
        rd_ack = 1'b0;
        checks++;
        if (reqSeen !== 0) begin
            failures++;
            $display("[TB] FAIL idle_no_req: got %0d active cycles expected 0", reqSeen);
        end
    endtask

    // Full frame with rd_ack and pix_ready held high; expL is the clamped layer count
    task automatic test_full_frame(input int nl, input int expL);
        int period;
        int lastT;
        int p;
        int ph;
        logic expReq, expNl, expNp, expFd, expBusy;
        int expLayer, expX, expY;
        logic [31:0] obs, exp;
        apply_reset();
        rd_ack = 1'b1;
        pix_ready = 1'b1;
        num_layers = 6'(nl);
        start = 1'b1;
        step();
        start = 1'b0;
        period = expL + 1;
        lastT = H * V * period;
        for (int t = 0; t <= lastT + 3; t++) begin
            expReq = 1'b0; expNl = 1'b0; expNp = 1'b0; expFd = 1'b0; expBusy = 1'b0;
            expLayer = 0; expX = 0; expY = 0;
            if (t < lastT) begin
                p = t / period;
                ph = t % period;
                expReq = (ph < expL);
                expLayer = (ph < expL) ? ph : expL - 1;
                expX = p % H;
                expY = p / H;
                expNl = (ph >= 1) && (ph <= expL - 1);
                expNp = (ph == 0) && (t > 0);
                expBusy = 1'b1;
            end else if (t == lastT) begin
                expNp = 1'b1;
                expBusy = 1'b1;
            end else if (t == lastT + 1) begin
                expFd = 1'b1;
                expBusy = 1'b1;
            end
            exp = {expReq, expNl, expNp, expFd, expBusy, 5'(expLayer), 11'(expX), 11'(expY)};
            obs = {rd_req, next_layer, next_pixel, frame_done, busy, layer, x, y};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL frame_nl%0d_t%0d: got %08h expected %08h", nl, t, obs, exp);
            end
            step();
        end
        rd_ack = 1'b0;
    endtask

    task automatic test_basic_frame();
        test_full_frame(3, 3);
    endtask

    task automatic test_clamping();
        test_full_frame(0, 1);
        test_full_frame(40, 32);
    endtask

    task automatic test_backpressure();
        apply_reset();
        num_layers = 6'd2;
        rd_ack = 1'b1;
        pix_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({rd_req, busy, layer} !== {1'b1, 1'b1, 5'd0}) begin
            failures++;
            $display("[TB] FAIL bp_first_req: got %0h expected %0h", {rd_req, busy, layer}, {1'b1, 1'b1, 5'd0});
        end
        step();
        rd_ack = 1'b0;
        checks++;
        if ({rd_req, next_layer, layer} !== {1'b1, 1'b1, 5'd1}) begin
            failures++;
            $display("[TB] FAIL bp_layer1: got %0h expected %0h", {rd_req, next_layer, layer}, {1'b1, 1'b1, 5'd1});
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({rd_req, next_layer, next_pixel, layer, x} !== {1'b1, 1'b0, 1'b0, 5'd1, 11'd0}) begin
                failures++;
                $display("[TB] FAIL bp_ack_stall_%0d: got %0h expected %0h", i,
                         {rd_req, next_layer, next_pixel, layer, x}, {1'b1, 1'b0, 1'b0, 5'd1, 11'd0});
            end
        end
        rd_ack = 1'b1;
        pix_ready = 1'b0;
        step();
        rd_ack = 1'b0;
        checks++;
        if ({rd_req, next_layer, layer, x} !== {1'b0, 1'b0, 5'd1, 11'd0}) begin
            failures++;
            $display("[TB] FAIL bp_enter_pix: got %0h expected %0h", {rd_req, next_layer, layer, x}, {1'b0, 1'b0, 5'd1, 11'd0});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({rd_req, next_pixel, busy, x} !== {1'b0, 1'b0, 1'b1, 11'd0}) begin
                failures++;
                $display("[TB] FAIL bp_pix_stall_%0d: got %0h expected %0h", i,
                         {rd_req, next_pixel, busy, x}, {1'b0, 1'b0, 1'b1, 11'd0});
            end
        end
        pix_ready = 1'b1;
        step();
        checks++;
        if ({rd_req, next_pixel, layer, x, y} !== {1'b1, 1'b1, 5'd0, 11'd1, 11'd0}) begin
            failures++;
            $display("[TB] FAIL bp_pix_release: got %0h expected %0h", {rd_req, next_pixel, layer, x, y},
                     {1'b1, 1'b1, 5'd0, 11'd1, 11'd0});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] obs;
        apply_reset();
        num_layers = 6'd3;
        rd_ack = 1'b1;
        pix_ready = 1'b1;
        start = 1'b1;
        step();
        num_layers = 6'd1;
        for (int i = 0; i < 25; i++) step();
        checks++;
        if ({rd_req, layer, x, y} !== {1'b1, 5'd1, 11'd2, 11'd1}) begin
            failures++;
            $display("[TB] FAIL mid_position: got %0h expected %0h", {rd_req, layer, x, y}, {1'b1, 5'd1, 11'd2, 11'd1});
        end
        start = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        num_layers = 6'd3;
        obs = {rd_req, next_layer, next_pixel, frame_done, busy, layer, x, y};
        checks++;
        if (obs !== 32'h0) begin
            failures++;
            $display("[TB] FAIL mid_reset_outputs: got %08h expected %08h", obs, 32'h0);
        end
        step();
        obs = {rd_req, next_layer, next_pixel, frame_done, busy, layer, x, y};
        checks++;
        if (obs !== 32'h0) begin
            failures++;
            $display("[TB] FAIL mid_reset_idle: got %08h expected %08h", obs, 32'h0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({rd_req, busy, layer, x, y} !== {1'b1, 1'b1, 5'd0, 11'd0, 11'd0}) begin
            failures++;
            $display("[TB] FAIL mid_restart: got %0h expected %0h", {rd_req, busy, layer, x, y},
                     {1'b1, 1'b1, 5'd0, 11'd0, 11'd0});
        end
        step();
        checks++;
        if ({rd_req, next_layer, layer} !== {1'b1, 1'b1, 5'd1}) begin
            failures++;
            $display("[TB] FAIL mid_restart_layer1: got %0h expected %0h", {rd_req, next_layer, layer}, {1'b1, 1'b1, 5'd1});
        end
    endtask

`ifdef SBX_LAYER_SKIP_EN
    task automatic test_skip();
        int ph;
        logic expReq, expNl, expNp;
        int expLayer;
        logic [31:0] obs, exp;
        apply_reset();
        layer_en = 32'hFFFF_FFFA;
        num_layers = 6'd4;
        rd_ack = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 10; t++) begin
            ph = t % 5;
            expReq = (ph == 1) || (ph == 3);
            expLayer = (ph < 4) ? ph : 3;
            expNl = (ph >= 1) && (ph <= 3);
            expNp = (ph == 0) && (t > 0);
            exp = {expReq, expNl, expNp, 1'b0, 1'b1, 5'(expLayer), 11'(t / 5), 11'd0};
            obs = {rd_req, next_layer, next_pixel, frame_done, busy, layer, x, y};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL skip_mask_t%0d: got %08h expected %08h", t, obs, exp);
            end
            step();
        end
        apply_reset();
        layer_en = 32'h0;
        rd_ack = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= 20; t++) begin
            exp = {1'b0, 1'b0, ((t % 5) == 0 && t > 0) ? 1'b1 : 1'b0, 11'((t / 5) % H), 11'((t / 5) / H)};
            obs = {1'b0, rd_req, next_pixel, x, y};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL skip_all_t%0d: got %08h expected %08h", t, obs, exp);
            end
            step();
        end
        layer_en = 32'hFFFF_FFFF;
        rd_ack = 1'b0;
    endtask
`endif

    // Scenario sequence and final summary
    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_clamping();
        test_reset_mid_frame();
`ifdef SBX_LAYER_SKIP_EN
        test_skip();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
